// File: rtl/debounced_counter_if.sv
// rtl/debounced_counter_if.sv - button/switch inputs and count outputs of debounced_counter
//
// Purpose: bundles the user-facing inputs (three raw buttons, slide switches)
// and the count outputs so the counter and its driver share one port.
//
// Signals:
//   BtnUp    1  raw asynchronous button, increments Value
//   BtnDown  1  raw asynchronous button, decrements Value
//   BtnLoad  1  raw asynchronous button, loads SW into Value
//   SW       8  slide switches, load data (quasi-static)
//   Value    8  current count, registered
//   Carry    1  one-cycle pulse on 255->0 wrap
//   Borrow   1  one-cycle pulse on 0->255 wrap
//
// Modports:
//   master  drives buttons and switches, observes the count
//   slave   the counter itself
interface debounced_counter_if;
  logic       BtnUp;
  logic       BtnDown;
  logic       BtnLoad;
  logic [7:0] SW;
  logic [7:0] Value;
  logic       Carry;
  logic       Borrow;

  modport master (
    output BtnUp,
    output BtnDown,
    output BtnLoad,
    output SW,
    input  Value,
    input  Carry,
    input  Borrow
  );

  modport slave (
    input  BtnUp,
    input  BtnDown,
    input  BtnLoad,
    input  SW,
    output Value,
    output Carry,
    output Borrow
  );
endinterface

// File: rtl/debounced_counter.sv
// rtl/debounced_counter.sv - synchronized, debounced up/down/load 8-bit counter
//
// Purpose: input stage ahead of the display multiplexer. Each raw button is
// synchronized (2 flops), debounced (DEBOUNCE_CYCLES stable cycles) and
// edge-detected so that every press yields exactly one count action.
// Value[3:0] / Value[7:4] feed the hex digit multiplexer.
//
// Ports:
//   Clk    1  system clock
//   Reset  1  synchronous, active-high reset, highest priority
//   bus    debounced_counter_if.slave (buttons, SW, Value, Carry, Borrow)
//
// Parameters:
//   DEBOUNCE_CYCLES  stable cycles before a new button level is accepted (>= 2)
//   CNT_W            debounce counter width, must hold DEBOUNCE_CYCLES-1
module debounced_counter #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 32
) (
  input  logic               Clk,
  input  logic               Reset,
  debounced_counter_if.slave bus
);

  localparam int                NUM_BTN = 3;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Bit positions of each button in the per-button vectors.
  localparam int BTN_UP   = 0;
  localparam int BTN_DOWN = 1;
  localparam int BTN_LOAD = 2;

  logic [NUM_BTN-1:0] btn_raw;

  // Two-flop synchronizer; sync2_q is the level seen by the debouncer.
  logic [NUM_BTN-1:0] sync1_q;
  logic [NUM_BTN-1:0] sync2_q;

  // Debounced level, its stability counter and the one-cycle press pulse.
  logic [NUM_BTN-1:0] deb_q;
  logic [NUM_BTN-1:0] deb_d;
  logic [CNT_W-1:0]   cnt_q [NUM_BTN];
  logic [CNT_W-1:0]   cnt_d [NUM_BTN];
  logic [NUM_BTN-1:0] press_q;
  logic [NUM_BTN-1:0] press_d;

  // Count state.
  logic [7:0] value_q;
  logic [7:0] value_d;
  logic       carry_q;
  logic       carry_d;
  logic       borrow_q;
  logic       borrow_d;

  assign btn_raw = {bus.BtnLoad, bus.BtnDown, bus.BtnUp};

  // Debouncer next state. The counter only runs while the synchronized level
  // disagrees with the accepted level; any agreement throws the partial count
  // away, so a glitch shorter than DEBOUNCE_CYCLES never reaches deb_q.
  // The press pulse fires only on an accepted 0->1 change, so releases are
  // debounced silently and a held button never repeats.
  always_comb begin
    deb_d   = deb_q;
    press_d = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          deb_d[i]   = sync2_q[i];
          press_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Count update. Load wins over everything; up and down together cancel.
  // Carry/Borrow default low so each is a single-cycle pulse.
  always_comb begin
    value_d  = value_q;
    carry_d  = 1'b0;
    borrow_d = 1'b0;
    if (press_q[BTN_LOAD]) begin
      value_d = bus.SW;
    end else if (press_q[BTN_UP] && press_q[BTN_DOWN]) begin
      value_d = value_q;
    end else if (press_q[BTN_UP]) begin
      value_d = value_q + 8'd1;
      carry_d = (value_q == 8'hFF);
    end else if (press_q[BTN_DOWN]) begin
      value_d  = value_q - 8'd1;
      borrow_d = (value_q == 8'h00);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      deb_q    <= '0;
      press_q  <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        cnt_q[i] <= '0;
      end
      value_q  <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      sync1_q  <= btn_raw;
      sync2_q  <= sync1_q;
      deb_q    <= deb_d;
      press_q  <= press_d;
      for (int i = 0; i < NUM_BTN; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      value_q  <= value_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
    end
  end

  assign bus.Value  = value_q;
  assign bus.Carry  = carry_q;
  assign bus.Borrow = borrow_q;

endmodule

// File: tb/tb_debounced_counter.sv
// tb/tb_debounced_counter.sv - directed self-checking bench for debounced_counter
module tb_debounced_counter;

  localparam int N = 4;

  logic Clk;
  logic Reset;
  int   checks;
  int   errors;
  int   carry_cnt;
  int   borrow_cnt;
  int   c_base;
  int   b_base;

  debounced_counter_if bus ();

  debounced_counter #(
    .DEBOUNCE_CYCLES (N),
    .CNT_W           (4)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Count pulse cycles shortly after each active edge.
  initial begin
    carry_cnt  = 0;
    borrow_cnt = 0;
    forever begin
      @(posedge Clk);
      #2;
      if (bus.Carry)  carry_cnt++;
      if (bus.Borrow) borrow_cnt++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // n active edges, then settle on the following falling edge.
  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic set_btn(input logic [2:0] m);
    bus.BtnUp   = m[0];
    bus.BtnDown = m[1];
    bus.BtnLoad = m[2];
  endtask

  // Press long enough for the update (edge k+N+2), then release fully.
  task automatic press(input logic [2:0] m, input int hold);
    set_btn(m);
    tick(hold);
    set_btn(3'b000);
    tick(N + 4);
  endtask

  task automatic mark_pulses;
    c_base = carry_cnt;
    b_base = borrow_cnt;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    Reset  = 1'b1;
    bus.SW = 8'h00;
    set_btn(3'b000);
    tick(3);
    check_eq("reset_value", 32'(bus.Value), 32'h00);
    check_eq("reset_carry", 32'(bus.Carry), 32'h0);
    check_eq("reset_borrow", 32'(bus.Borrow), 32'h0);
    Reset = 1'b0;
    tick(2);

    // 1: three exact-latency increments, no carry
    mark_pulses();
    for (int p = 0; p < 3; p++) begin
      set_btn(3'b001);
      tick(N + 2);
      check_eq("t1_before_edge", 32'(bus.Value), 32'(p));
      tick(1);
      check_eq("t1_at_edge", 32'(bus.Value), 32'(p + 1));
      tick(2);
      set_btn(3'b000);
      tick(N + 4);
    end
    check_eq("t1_no_carry", 32'(carry_cnt - c_base), 32'd0);

    // 2: bounce then steady hold gives one increment
    for (int b = 0; b < 2; b++) begin
      set_btn(3'b001);
      tick(2);
      set_btn(3'b000);
      tick(2);
    end
    check_eq("t2_bounce_ignored", 32'(bus.Value), 32'h03);
    press(3'b001, 10);
    check_eq("t2_one_inc", 32'(bus.Value), 32'h04);

    // 3: wrap in both directions
    bus.SW = 8'hFF;
    press(3'b100, N + 3);
    check_eq("t3_load_ff", 32'(bus.Value), 32'hFF);
    mark_pulses();
    press(3'b001, N + 3);
    check_eq("t3_wrap_up", 32'(bus.Value), 32'h00);
    check_eq("t3_carry_1cyc", 32'(carry_cnt - c_base), 32'd1);
    check_eq("t3_no_borrow_up", 32'(borrow_cnt - b_base), 32'd0);
    mark_pulses();
    press(3'b010, N + 3);
    check_eq("t3_wrap_down", 32'(bus.Value), 32'hFF);
    check_eq("t3_borrow_1cyc", 32'(borrow_cnt - b_base), 32'd1);
    check_eq("t3_no_carry_down", 32'(carry_cnt - c_base), 32'd0);

    // 4: up+down cancel, load wins over both
    bus.SW = 8'h10;
    press(3'b100, N + 3);
    mark_pulses();
    press(3'b011, N + 3);
    check_eq("t4_updown_hold", 32'(bus.Value), 32'h10);
    check_eq("t4_no_carry", 32'(carry_cnt - c_base), 32'd0);
    check_eq("t4_no_borrow", 32'(borrow_cnt - b_base), 32'd0);
    bus.SW = 8'h5A;
    press(3'b111, N + 3);
    check_eq("t4_load_wins", 32'(bus.Value), 32'h5A);

    // 5: long hold is a single decrement
    bus.SW = 8'h03;
    press(3'b100, N + 3);
    set_btn(3'b010);
    tick(100);
    check_eq("t5_held", 32'(bus.Value), 32'h02);
    set_btn(3'b000);
    tick(N + 4);
    press(3'b010, N + 3);
    check_eq("t5_repress", 32'(bus.Value), 32'h01);

    // 6: reset while the debounce counter is at 2
    set_btn(3'b001);
    tick(4);
    Reset = 1'b1;
    tick(1);
    check_eq("t6_in_reset", 32'(bus.Value), 32'h00);
    Reset = 1'b0;
    tick(N + 2);
    check_eq("t6_before", 32'(bus.Value), 32'h00);
    tick(1);
    check_eq("t6_after", 32'(bus.Value), 32'h01);
    tick(20);
    check_eq("t6_once", 32'(bus.Value), 32'h01);
    set_btn(3'b000);
    tick(N + 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/debounced_counter.md
Name: debounced_counter

Overview:
- Input stage that sits directly upstream of the display multiplexer.
- Takes three raw push-buttons (up, down, load) and the 8 slide switches, and maintains an 8-bit count in Value.
- Buttons pass through a synchronizer and a debouncer, then an edge detector; each press produces exactly one count action.
- Value[3:0] drives multiplexer In0 and Value[7:4] drives In1, so the 7-segment digits display the count in hex.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required before a button level is accepted (10 ms at 100 MHz); legal range is 2 or more.
- CNT_W, 32, width of each debounce counter; must hold DEBOUNCE_CYCLES-1.

Ports:
- Clk  input  1  system clock (100 MHz)
- Reset  input  1  synchronous, active-high reset
- BtnUp  input  1  raw asynchronous button, increments Value
- BtnDown  input  1  raw asynchronous button, decrements Value
- BtnLoad  input  1  raw asynchronous button, loads SW into Value
- SW  input  8  slide switches, load data
- Value  output  8  current count, registered
- Carry  output  1  one-cycle pulse on 255->0 wrap
- Borrow  output  1  one-cycle pulse on 0->255 wrap

Behaviour:
- Clocking and reset:
  - Single clock, Clk.
  - Reset is synchronous and active-high. It is sampled at the Clk edge and has priority over everything.
  - Reset clears to 0: all synchronizer flops, debounced states, debounce counters, internal press pulses, Value, Carry and Borrow.
- Synchronizer: each raw button goes through 2 flops (s1, s2). s2 is the synchronized level.
- Debouncer (one per button, identical):
  - Holds a debounced state d and a counter c.
  - When s2 == d: c <= 0.
  - When s2 != d and c < DEBOUNCE_CYCLES-1: c <= c+1.
  - When s2 != d and c == DEBOUNCE_CYCLES-1: d <= s2 and c <= 0.
  - On the same edge that d goes 0->1, the internal press pulse p is set to 1. p returns to 0 on the next edge.
  - A release (d goes 1->0) is also debounced but produces no pulse.
  - A mismatch lasting fewer than DEBOUNCE_CYCLES cycles resets c and causes no change to d.
  - A held button produces exactly one pulse; there is no auto-repeat.
- Latency: with a level first captured by s1 at edge k, s2 changes at edge k+1, d and p rise at edge k+N+1, and Value updates at edge k+N+2 (N = DEBOUNCE_CYCLES).
- Count update, evaluated each edge in priority order:
  1. Reset: Value <= 0.
  2. pLoad: Value <= SW, sampled at that edge. No Carry or Borrow.
  3. pUp and pDown together: Value unchanged. No Carry or Borrow.
  4. pUp: Value <= Value+1 modulo 256. Carry <= 1 when the old Value was 255.
  5. pDown: Value <= Value-1 modulo 256. Borrow <= 1 when the old Value was 0.
- Carry and Borrow are 0 on every edge that does not meet the conditions above, so each is a single-cycle pulse.
- Arithmetic is 8-bit unsigned and wraps; there is no saturation.
- Reset mid-operation:
  - Any partially counted debounce is discarded.
  - A button still held when Reset deasserts is treated as a new press: one pulse after N+1 edges of normal debounce.
- SW is treated as quasi-static and is not synchronized. It is sampled only on the pLoad edge.
- No combinational path exists from any input to any output.

Test Plan:
1. Reset, then hold BtnUp for 3 presses with DEBOUNCE_CYCLES=4, releasing for at least 6 cycles between presses -> Value goes 0,1,2,3; each change occurs exactly at edge k+6 relative to the s1 capture; Carry stays 0.
2. Bounce test, DEBOUNCE_CYCLES=4: BtnUp toggles 1,0,1,0 with 2-cycle highs, then holds high for 10 cycles -> exactly one increment, Value 0->1.
3. Wrap: BtnLoad with SW=8'hFF -> Value=8'hFF. Press BtnUp -> Value=8'h00 and Carry high for exactly 1 cycle. Press BtnDown -> Value=8'hFF and Borrow high for exactly 1 cycle.
4. Simultaneous: with Value=8'h10, press BtnUp and BtnDown with identical timing -> Value stays 8'h10; Carry and Borrow stay 0. With BtnLoad also pulsed on the same edge and SW=8'h5A -> Value=8'h5A.
5. Hold: BtnDown held 100 cycles from Value=8'h03 -> Value=8'h02 only; after release and re-press -> 8'h01.
6. Reset mid-debounce: BtnUp high, assert Reset at c=2 for 1 cycle while BtnUp stays high -> Value=0 during Reset; Value becomes 1 exactly once, N+2 edges after s1 recaptures the button, i.e. N+3 edges after Reset deasserts.
